product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
//  Downstream stage of the 8-bit multiplier. Accepts a stream of 16-bit unsigned products over a valid/ready handshake.
//  Sums BLOCK_LEN consecutive products into a saturating accumulator and presents each block sum on a valid/ready output.
//  Forms the accumulate half of a multiply-accumulate (dot-product) datapath; the multiplier output drives Product_In directly.
// PARAMETERS
//  PROD_WIDTH  16  width of incoming product (unsigned)
//  ACC_WIDTH   24  accumulator/sum width; must be >= PROD_WIDTH
//  BLOCK_LEN   8   products summed per output block; must be >= 1
// PORTS
//  Clock_In           in   1           single clock, all logic on rising edge
//  Reset_n_In         in   1           synchronous, active-low reset
//  Clear_In           in   1           synchronous abort: drop partial/held block
//  Product_In         in   PROD_WIDTH  product from multiplier
//  Product_Valid_In   in   1           Product_In is valid
//  Product_Ready_Out  out  1           stage can accept a product this cycle
//  Sum_Out            out  ACC_WIDTH   completed block sum
//  Sum_Valid_Out      out  1           Sum_Out/Overflow_Out are valid
//  Sum_Ready_In       in   1           consumer accepts sum this cycle
//  Overflow_Out       out  1           block sum saturated (qualified by Sum_Valid_Out)
// BEHAVIOUR
//  Reset (Reset_n_In=0 at an edge): state=ACCUM, acc=0, count=0, sticky ovf=0; Sum_Out=0, Sum_Valid_Out=0, Overflow_Out=0, Product_Ready_Out=1 from the next cycle.
//   Reset mid-block or mid-hold discards all data.
//  Accept  = Product_Valid_In & Product_Ready_Out. Deliver = Sum_Valid_Out & Sum_Ready_In.
//  FSM, 2 states:
//   ACCUM: Product_Ready_Out=1, Sum_Valid_Out=0.
//    - On accept: acc <= sat(acc + zero_ext(Product_In)); count++; ovf |= carry-out.
//    - If that accept is the BLOCK_LEN-th: Sum_Out <= final sum; Overflow_Out <= final ovf; acc, count, ovf <= 0; go to HOLD.
//    - Sum_Valid_Out rises the cycle after the last accept (latency 1).
//   HOLD: Product_Ready_Out=0, Sum_Valid_Out=1; Sum_Out/Overflow_Out held stable until delivered.
//    - On deliver: Sum_Valid_Out <= 0, go to ACCUM; accepting resumes the cycle after deliver (no bypass).
//  Product_Ready_Out is a pure function of state, with no combinational path from Sum_Ready_In.
//  Saturation: if acc + product > 2^ACC_WIDTH-1, acc <= 2^ACC_WIDTH-1 and ovf sets. Further adds stay saturated; no wrap-around.
//  Clear_In=1 (priority over accept/deliver, below reset):
//   - acc, count, ovf <= 0; state <= ACCUM; Sum_Valid_Out <= 0.
//   - A product presented in the same cycle is discarded.
//   - A held sum is dropped without delivery.
//  Product_Valid_In low in ACCUM: state unchanged; gaps between products are allowed.
//  Sum_Out is stable while Sum_Valid_Out=1 and Sum_Ready_In=0.
//  BLOCK_LEN=1: every accepted product goes straight to HOLD.
//  count width = $clog2(BLOCK_LEN+1).
// STRUCTURE
//  Package product_accumulator_pkg holds:
//   - typedef enum logic {ACCUM, HOLD} acc_state_t
//   - localparams for default widths and BLOCK_LEN
//  One sub-module: saturating_adder, parameterised on ACC_WIDTH.
//   Inputs: a, zero-extended b. Outputs: sat_sum, ovf.
//  The FSM, counter and output registers live in product_accumulator.
// TESTING
//  Defaults; after reset -> Sum_Valid_Out=0, Sum_Out=0, Product_Ready_Out=1.
//  Defaults; products 1..8 back-to-back, Sum_Ready_In=1 -> Sum_Valid_Out=1 one cycle after the 8th accept, Sum_Out=36, Overflow_Out=0; Product_Ready_Out=0 for exactly 1 cycle.
//  Defaults; 8 x 16'hFFFF -> Sum_Out=524280 (24'h07FFF8), Overflow_Out=0.
//   Repeat with ACC_WIDTH=18 -> Sum_Out=18'h3FFFF, Overflow_Out=1.
//  Sum_Ready_In=0 for 5 cycles after a block with sum 100 -> Sum_Out holds 100, Product_Ready_Out=0 with Product_Valid_In=1 held.
//   Raise Sum_Ready_In -> delivered once; the next block then starts from 0.
//  Feed 3 products (10,20,30), pulse Clear_In together with a 4th product (40), then feed 8 x 5 -> Sum_Out=40.
//  Reset_n_In low for 1 cycle while in HOLD -> Sum_Valid_Out=0 next cycle; the following block sum is uncontaminated.
//  Random valid gaps and backpressure, 1000 blocks -> every Sum_Out matches the reference-model sum and no product is lost or duplicated.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared types and default sizing for the product accumulator stage.
// Imported by the accumulator top and its saturating adder.
package product_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    localparam int unsigned DEF_PROD_WIDTH = 16;
    localparam int unsigned DEF_ACC_WIDTH  = 24;
    localparam int unsigned DEF_BLOCK_LEN  = 8;

endpackage

// File: rtl/product_accumulator_saturating_adder.sv
// Unsigned adder that clamps to all-ones instead of wrapping.
// ovf reports the carry-out of the unclamped sum.
module saturating_adder #(
    parameter int unsigned ACC_WIDTH = 24
) (
    input  logic [ACC_WIDTH-1:0] a,
    input  logic [ACC_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0] sat_sum,
    output logic                 ovf
);

    logic [ACC_WIDTH:0] full_sum_s;

    assign full_sum_s = {1'b0, a} + {1'b0, b};
    assign ovf        = full_sum_s[ACC_WIDTH];
    assign sat_sum    = full_sum_s[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : full_sum_s[ACC_WIDTH-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Sums BLOCK_LEN unsigned products into a saturating accumulator and hands
// each block sum downstream on a valid/ready port, holding it until taken.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int unsigned PROD_WIDTH = DEF_PROD_WIDTH,
    parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int unsigned BLOCK_LEN  = DEF_BLOCK_LEN
) (
    input  logic                  Clock_In,
    input  logic                  Reset_n_In,
    input  logic                  Clear_In,
    input  logic [PROD_WIDTH-1:0] Product_In,
    input  logic                  Product_Valid_In,
    output logic                  Product_Ready_Out,
    output logic [ACC_WIDTH-1:0]  Sum_Out,
    output logic                  Sum_Valid_Out,
    input  logic                  Sum_Ready_In,
    output logic                  Overflow_Out
);

    localparam int unsigned CNT_W = $clog2(BLOCK_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

    acc_state_t             state_r;
    logic [ACC_WIDTH-1:0]   acc_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   ovf_r;
    logic [ACC_WIDTH-1:0]   sum_r;
    logic                   sum_valid_r;
    logic                   ovf_out_r;

    logic [ACC_WIDTH-1:0]   prod_ext_s;
    logic [ACC_WIDTH-1:0]   add_sum_s;
    logic                   add_ovf_s;
    logic                   accept_s;
    logic                   block_ovf_s;

    assign prod_ext_s  = ACC_WIDTH'(Product_In);
    assign accept_s    = Product_Valid_In & (state_r == ACCUM);
    assign block_ovf_s = ovf_r | add_ovf_s;

    saturating_adder #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sat_add (
        .a       (acc_r),
        .b       (prod_ext_s),
        .sat_sum (add_sum_s),
        .ovf     (add_ovf_s)
    );

    // Block FSM: accumulate until BLOCK_LEN accepts, then hold the sum until delivered.
    always_ff @(posedge Clock_In) begin
        if (!Reset_n_In) begin
            state_r     <= ACCUM;
            acc_r       <= {ACC_WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            sum_r       <= {ACC_WIDTH{1'b0}};
            sum_valid_r <= 1'b0;
            ovf_out_r   <= 1'b0;
        end else if (Clear_In) begin
            state_r     <= ACCUM;
            acc_r       <= {ACC_WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            sum_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (accept_s) begin
                        if (cnt_r == LAST_CNT) begin
                            sum_r       <= add_sum_s;
                            ovf_out_r   <= block_ovf_s;
                            sum_valid_r <= 1'b1;
                            acc_r       <= {ACC_WIDTH{1'b0}};
                            cnt_r       <= {CNT_W{1'b0}};
                            ovf_r       <= 1'b0;
                            state_r     <= HOLD;
                        end else begin
                            acc_r <= add_sum_s;
                            cnt_r <= cnt_r + CNT_W'(1);
                            ovf_r <= block_ovf_s;
                        end
                    end
                end
                HOLD: begin
                    // No bypass: a new product is only taken the cycle after delivery.
                    if (Sum_Ready_In) begin
                        sum_valid_r <= 1'b0;
                        state_r     <= ACCUM;
                    end
                end
                default: begin
                    state_r     <= ACCUM;
                    sum_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign Product_Ready_Out = (state_r == ACCUM);
    assign Sum_Out           = sum_r;
    assign Sum_Valid_Out     = sum_valid_r;
    assign Overflow_Out      = ovf_out_r;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed and randomised bench for product_accumulator: two instances
// (24-bit and 18-bit accumulators) share one stimulus and one block-sum model.
module tb_product_accumulator;

    localparam int BLOCK_LEN = 8;
    localparam longint MAX24 = 64'd16777215;
    localparam longint MAX18 = 64'd262143;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [15:0] prod;
    logic        pvalid;
    logic        sready;

    logic        rdy24, sv24, ovf24;
    logic [23:0] sum24;
    logic        rdy18, sv18, ovf18;
    logic [17:0] sum18;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model state: raw unclamped block total, clamped per width at compare time
    bit     m_hold = 1'b0;
    longint m_sum  = 0;
    int     m_cnt  = 0;
    longint m_exp  = 0;
    int     m_delivered = 0;

    always #5 clk = ~clk;

    product_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(24), .BLOCK_LEN(BLOCK_LEN)) dut24 (
        .Clock_In(clk), .Reset_n_In(rst_n), .Clear_In(clr),
        .Product_In(prod), .Product_Valid_In(pvalid), .Product_Ready_Out(rdy24),
        .Sum_Out(sum24), .Sum_Valid_Out(sv24), .Sum_Ready_In(sready), .Overflow_Out(ovf24)
    );

    product_accumulator #(.PROD_WIDTH(16), .ACC_WIDTH(18), .BLOCK_LEN(BLOCK_LEN)) dut18 (
        .Clock_In(clk), .Reset_n_In(rst_n), .Clear_In(clr),
        .Product_In(prod), .Product_Valid_In(pvalid), .Product_Ready_Out(rdy18),
        .Sum_Out(sum18), .Sum_Valid_Out(sv18), .Sum_Ready_In(sready), .Overflow_Out(ovf18)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [15:0] p, input bit r, input bit c);
        @(negedge clk);
        pvalid = v;
        prod   = p;
        sready = r;
        clr    = c;
    endtask

    // Block-level reference: count accepts, total them, hold until taken.
    always @(posedge clk) begin
        if (!rst_n || clr) begin
            m_hold <= 1'b0;
            m_sum  <= 0;
            m_cnt  <= 0;
        end else if (!m_hold) begin
            if (pvalid) begin
                if (m_cnt == BLOCK_LEN - 1) begin
                    m_exp  <= m_sum + longint'(prod);
                    m_hold <= 1'b1;
                    m_sum  <= 0;
                    m_cnt  <= 0;
                end else begin
                    m_sum <= m_sum + longint'(prod);
                    m_cnt <= m_cnt + 1;
                end
            end
        end else if (sready) begin
            m_hold      <= 1'b0;
            m_delivered <= m_delivered + 1;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("sv24", 64'(sv24), 64'(m_hold));
            check("rdy24", 64'(rdy24), 64'(!m_hold));
            check("sv18", 64'(sv18), 64'(m_hold));
            check("rdy18", 64'(rdy18), 64'(!m_hold));
            if (m_hold) begin
                check("sum24", 64'(sum24), (m_exp > MAX24) ? MAX24 : m_exp);
                check("ovf24", 64'(ovf24), 64'(m_exp > MAX24));
                check("sum18", 64'(sum18), (m_exp > MAX18) ? MAX18 : m_exp);
                check("ovf18", 64'(ovf18), 64'(m_exp > MAX18));
            end
        end
    end

    initial begin
        int target;
        int cyc;
        rst_n = 1'b0; clr = 1'b0; prod = 16'd0; pvalid = 1'b0; sready = 1'b0;
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        check("rst_sv", 64'(sv24), 64'd0);
        check("rst_sum", 64'(sum24), 64'd0);
        check("rst_ovf", 64'(ovf24), 64'd0);
        check("rst_rdy", 64'(rdy24), 64'd1);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // products 1..8 back-to-back, consumer always ready
        for (int i = 1; i <= 8; i++) drive(1'b1, 16'(i), 1'b1, 1'b0);
        drive(1'b0, 16'd0, 1'b1, 1'b0);
        check("seq_sv", 64'(sv24), 64'd1);
        check("seq_sum", 64'(sum24), 64'd36);
        check("seq_ovf", 64'(ovf24), 64'd0);
        check("seq_rdy_low", 64'(rdy24), 64'd0);
        drive(1'b0, 16'd0, 1'b1, 1'b0);
        check("seq_rdy_back", 64'(rdy24), 64'd1);
        check("seq_sv_drop", 64'(sv24), 64'd0);

        // full-scale products: fits in 24 bits, saturates in 18
        for (int i = 0; i < 8; i++) drive(1'b1, 16'hFFFF, 1'b1, 1'b0);
        drive(1'b0, 16'd0, 1'b1, 1'b0);
        check("ffff_sum24", 64'(sum24), 64'd524280);
        check("ffff_ovf24", 64'(ovf24), 64'd0);
        check("ffff_sum18", 64'(sum18), 64'h3FFFF);
        check("ffff_ovf18", 64'(ovf18), 64'd1);

        // backpressure: sum 100 held for 5 cycles with a product waiting
        drive(1'b1, 16'd10, 1'b0, 1'b0);
        drive(1'b1, 16'd20, 1'b0, 1'b0);
        drive(1'b1, 16'd30, 1'b0, 1'b0);
        drive(1'b1, 16'd40, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 16'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'd99, 1'b0, 1'b0);
            check("hold_sum", 64'(sum24), 64'd100);
            check("hold_rdy", 64'(rdy24), 64'd0);
        end
        drive(1'b1, 16'd99, 1'b1, 1'b0);
        drive(1'b1, 16'd99, 1'b1, 1'b0);
        check("hold_released", 64'(rdy24), 64'd1);
        for (int i = 0; i < 7; i++) drive(1'b1, 16'd1, 1'b0, 1'b0);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        check("next_block_sum", 64'(sum24), 64'd106);
        drive(1'b0, 16'd0, 1'b1, 1'b0);

        // clear with a concurrent product drops both partial block and that product
        drive(1'b1, 16'd10, 1'b1, 1'b0);
        drive(1'b1, 16'd20, 1'b1, 1'b0);
        drive(1'b1, 16'd30, 1'b1, 1'b0);
        drive(1'b1, 16'd40, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) drive(1'b1, 16'd5, 1'b0, 1'b0);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        check("clear_sum", 64'(sum24), 64'd40);
        check("clear_sv", 64'(sv24), 64'd1);
        drive(1'b0, 16'd0, 1'b0, 1'b1);
        check("clear_drops_held", 64'(sv24), 64'd1);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        check("clear_held_gone", 64'(sv24), 64'd0);

        // reset while holding a sum
        for (int i = 0; i < 8; i++) drive(1'b1, 16'd3, 1'b0, 1'b0);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        check("pre_rst_sum", 64'(sum24), 64'd24);
        rst_n = 1'b0;
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        check("rst_hold_sv", 64'(sv24), 64'd0);
        for (int i = 1; i <= 8; i++) drive(1'b1, 16'(i), 1'b0, 1'b0);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        check("post_rst_sum", 64'(sum24), 64'd36);
        drive(1'b0, 16'd0, 1'b1, 1'b0);

        // random gaps and backpressure over 1000 blocks
        target = m_delivered + 1000;
        cyc = 0;
        while (m_delivered < target && cyc < 60000) begin
            drive(($urandom_range(0, 3) != 0), 16'($urandom_range(0, 65535)),
                  ($urandom_range(0, 4) < 3), 1'b0);
            cyc++;
        end
        check("random_blocks_done", 64'(m_delivered), 64'(target));

        drive(1'b0, 16'd0, 1'b0, 1'b0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
